// File: rtl/i2c_temp_slave.sv
// Read-only I2C target emulating a two-byte temperature sensor.
// Answers DEV_ADDR with R/W=1 and returns a 16-bit word snapshotted at address match.
module i2c_temp_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_TX, S_RX_ACK, S_WAIT_STOP
  } state_t;

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  state_t      state_q, state_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_sel_q, byte_sel_d;
  logic [15:0] tx_word_q, tx_word_d;
  logic        ack_q, ack_d;

  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] next_byte;

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;

  assign scl_sync_d = {scl_sync_q[1:0], scl};
  assign sda_sync_d = {sda_sync_q[1:0], sda};
  assign scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_ev   = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_ev    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
  // Byte that follows a master ACK: toggled select, same snapshot
  assign next_byte  = byte_sel_q ? tx_word_q[15:8] : tx_word_q[7:0];

  always_comb begin
    state_d    = state_q;
    oe_d       = oe_q;
    rd_done_d  = 1'b0;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_sel_d = byte_sel_q;
    tx_word_d  = tx_word_q;
    ack_d      = ack_q;

    case (state_q)
      S_IDLE: oe_d = 1'b0;
      S_ADDR: begin
        if (scl_rise) begin
          shreg_d   = {shreg_q[6:0], sda_sync_q[1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          if (shreg_q[7:1] == DEV_ADDR && shreg_q[0]) begin
            oe_d       = 1'b1;
            tx_word_d  = temp_data;
            byte_sel_d = 1'b0;
            state_d    = S_ADDR_ACK;
          end else begin
            oe_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_ADDR_ACK: if (scl_fall) begin
        shreg_d   = tx_word_q[15:8];
        oe_d      = ~tx_word_q[15];
        bit_cnt_d = 4'd1;
        state_d   = S_TX;
      end
      S_TX: if (scl_fall) begin
        if (bit_cnt_q < 4'd8) begin
          oe_d      = ~shreg_q[6];
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          oe_d    = 1'b0;
          state_d = S_RX_ACK;
        end
      end
      S_RX_ACK: begin
        if (scl_rise) ack_d = ~sda_sync_q[1];
        else if (scl_fall) begin
          if (ack_q) begin
            byte_sel_d = ~byte_sel_q;
            shreg_d    = next_byte;
            oe_d       = ~next_byte[7];
            bit_cnt_d  = 4'd1;
            state_d    = S_TX;
          end else begin
            rd_done_d = 1'b1;
            oe_d      = 1'b0;
            state_d   = S_WAIT_STOP;
          end
        end
      end
      S_WAIT_STOP: oe_d = 1'b0;
      default: begin
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Bus conditions override whatever the byte-level FSM decided
    if (stop_ev) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      oe_d      = 1'b0;
      bit_cnt_d = 4'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_done_q  <= 1'b0;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      byte_sel_q <= 1'b0;
      tx_word_q  <= 16'h0000;
      ack_q      <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rd_done_q  <= rd_done_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_sel_q <= byte_sel_d;
      tx_word_q  <= tx_word_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_i2c_temp_slave.sv
// Bench for i2c_temp_slave: bit-banged I2C master, expected-byte scoreboard queue.
module tb_i2c_temp_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  logic [15:0] temp_data = 16'h1A80;
  logic        busy, rd_done;
  wire         sda;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_temp_slave #(.DEV_ADDR(7'h48)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .temp_data(temp_data), .busy(busy), .rd_done(rd_done)
  );

  always #10 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] exp_q[$];
  int rd_cnt = 0;
  int rd_wide = 0;
  logic rd_prev = 1'b0;

  always @(negedge clk) begin
    if (rd_done === 1'b1) rd_cnt++;
    if (rd_done === 1'b1 && rd_prev === 1'b1) rd_wide++;
    rd_prev = rd_done;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit, actual=running required=done");
    $fatal(1, "timeout");
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; wt(50);
    scl = 1'b1;  wt(50);
    m_oe = 1'b1; wt(50);
    scl = 1'b0;  wt(50);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; wt(50);
    scl = 1'b1;  wt(50);
    m_oe = 1'b0; wt(50);
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b;  wt(50);
    scl = 1'b1; wt(100);
    scl = 1'b0; wt(50);
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; wt(50);
    scl = 1'b1;  wt(50);
    b = sda;     wt(50);
    scl = 1'b0;  wt(50);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full master read. stop_bit>=0 aborts byte 0 with a STOP after that many bits;
  // chg_bit>=0 changes temp_data after that bit of byte 0.
  task automatic xfer(input logic [7:0] ab, input int nbytes, input int stop_bit,
                      input int chg_bit, input logic [15:0] chg_val);
    logic a;
    logic exp_a;
    logic [7:0] d;
    logic [7:0] e;
    exp_a = (ab[7:1] == 7'h48 && ab[0]) ? 1'b0 : 1'b1;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(ab[i]);
    read_bit(a);
    chk("addr_ack", {15'd0, a}, {15'd0, exp_a});
    if (exp_a) begin
      chk("busy_after_nak", {15'd0, busy}, 16'd0);
      i2c_stop();
      return;
    end
    chk("busy_in_xfer", {15'd0, busy}, 16'd1);
    for (int b = 0; b < nbytes; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (b == 0 && j == stop_bit) begin
          m_oe = 1'b1; wt(50);
          scl = 1'b1;  wt(50);
          m_oe = 1'b0; wt(6);
          chk("sda_rel_after_stop", {15'd0, sda}, 16'd1);
          chk("busy_after_stop", {15'd0, busy}, 16'd0);
          wt(44);
          return;
        end
        read_bit(d[7-j]);
        if (b == 0 && j == chg_bit) temp_data = chg_val;
      end
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL data_byte: actual=%h required=none (queue empty)", d);
      end else begin
        e = exp_q.pop_front();
        chk("data_byte", {8'd0, d}, {8'd0, e});
      end
      send_bit(b == nbytes - 1);
    end
    i2c_stop();
    wt(10);
    chk("busy_idle", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_reset();
    logic a, d;
    wt(5);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rd_done", {15'd0, rd_done}, 16'd0);
    chk("rst_sda", {15'd0, sda}, 16'd1);
    rst_n = 1'b1; wt(20);
    // Reset again in the middle of TX, while the target holds sda low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h91 >> i);
    read_bit(a);
    chk("rst_pre_ack", {15'd0, a}, 16'd0);
    read_bit(d); read_bit(d);
    m_oe = 1'b0; wt(10);
    chk("tx_bit5_low", {15'd0, sda}, 16'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midtx_rst_sda", {15'd0, sda}, 16'd1);
    chk("midtx_rst_busy", {15'd0, busy}, 16'd0);
    chk("midtx_rst_rd_done", {15'd0, rd_done}, 16'd0);
    scl = 1'b1; wt(20);
    rst_n = 1'b1; wt(50);
    chk("post_rst_idle", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_read();
    int r0;
    temp_data = 16'h1A80;
    exp_q.push_back(8'h1A); exp_q.push_back(8'h80);
    r0 = rd_cnt;
    xfer(8'h91, 2, -1, -1, 16'h0);
    chk("read_rd_done", rd_cnt[15:0], 16'(r0 + 1));
  endtask

  task automatic test_mismatch();
    int r0;
    r0 = rd_cnt;
    xfer(8'h93, 0, -1, -1, 16'h0);
    xfer(8'h90, 0, -1, -1, 16'h0);
    chk("nak_rd_done", rd_cnt[15:0], 16'(r0));
  endtask

  task automatic test_continuous();
    int r0;
    exp_q.push_back(8'h1A); exp_q.push_back(8'h80); exp_q.push_back(8'h1A);
    r0 = rd_cnt;
    xfer(8'h91, 3, -1, -1, 16'h0);
    chk("cont_rd_done", rd_cnt[15:0], 16'(r0 + 1));
  endtask

  task automatic test_snapshot();
    exp_q.push_back(8'h1A); exp_q.push_back(8'h80);
    xfer(8'h91, 2, -1, 2, 16'h0000);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    xfer(8'h91, 2, -1, -1, 16'h0);
    temp_data = 16'h1A80;
  endtask

  task automatic test_stop_restart();
    int r0;
    r0 = rd_cnt;
    xfer(8'h91, 2, 4, -1, 16'h0);
    chk("abort_rd_done", rd_cnt[15:0], 16'(r0));
    exp_q.push_back(8'h1A); exp_q.push_back(8'h80);
    xfer(8'h91, 2, -1, -1, 16'h0);
    chk("restart_rd_done", rd_cnt[15:0], 16'(r0 + 1));
  endtask

  initial begin
    test_reset();
    test_read();
    test_mismatch();
    test_continuous();
    test_snapshot();
    test_stop_restart();
    chk("rd_done_width", rd_wide[15:0], 16'd0);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
